uart_tx_arbiter: RTL and testbench

Shares one UART transmit line between `N_REQ` independent byte producers, such as the switch-send path, the monitor and debug logic. Arbitration is round-robin. The granted byte is framed as 8N1 (LSB first) at a fixed bit period. The block sits between the requesters and the board `tx_o` pin, replacing the single-source send counter and bit mux.

---
 rtl/uart_tx_arb_pkg.sv | 18 +
 rtl/uart_tx_serializer.sv | 125 ++++++++++++
 rtl/uart_tx_arbiter.sv | 85 ++++++++
 tb/tb_uart_tx_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the round-robin UART transmit arbiter.
//   tx_state_t            serializer FSM state encoding
//   FRAME_BITS            bit cells per frame (10 for 8N1, 11 for 8E1)
//   DEFAULT_CLKS_PER_BIT  default baud divider
// Optional feature macro: UART_TX_ARB_PARITY_EN (adds an even-parity cell).
package uart_tx_arb_pkg;

`ifdef UART_TX_ARB_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  localparam int unsigned FRAME_BITS = 11;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam int unsigned FRAME_BITS = 10;
`endif

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 8680;

endpackage

// File: rtl/uart_tx_serializer.sv
// Byte serializer: frames a captured byte as 8N1 (8E1 with
// UART_TX_ARB_PARITY_EN defined), LSB first, CLKS_PER_BIT cycles per bit.
// Ports:
//   clk_i    system clock
//   rst_i    asynchronous active-low reset
//   start_i  capture data_i and begin a frame (honoured only in IDLE)
//   data_i   byte to send
//   busy_o   high from first START cycle through last STOP cycle
//   tx_o     registered serial line, idle high
module uart_tx_serializer
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       busy_o,
  output logic       tx_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  tx_state_t        state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
`ifdef UART_TX_ARB_PARITY_EN
  logic             parity;
`endif

  logic baud_end;
  assign baud_end = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

  // tx_o is loaded with the level of the state being entered, so the line
  // changes on the same edge as the state and never glitches.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      busy_o   <= 1'b0;
      tx_o     <= 1'b1;
`ifdef UART_TX_ARB_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (start_i) begin
            shreg  <= data_i;
`ifdef UART_TX_ARB_PARITY_EN
            parity <= ^data_i;
`endif
            state  <= START;
            busy_o <= 1'b1;
            tx_o   <= 1'b0;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= DATA;
            tx_o     <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            shreg    <= {1'b0, shreg[7:1]};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_ARB_PARITY_EN
              state <= PARITY;
              tx_o  <= parity;
`else
              state <= STOP;
              tx_o  <= 1'b1;
`endif
            end else begin
              // shreg[1] becomes shreg[0] after this shift
              tx_o <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef UART_TX_ARB_PARITY_EN
        PARITY: begin
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= STOP;
            tx_o     <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= IDLE;
            busy_o   <= 1'b0;
            tx_o     <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          baud_cnt <= '0;
          state    <= IDLE;
          busy_o   <= 1'b0;
          tx_o     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit line among N_REQ byte
// producers. Frame format 8N1, or 8E1 with UART_TX_ARB_PARITY_EN defined.
// Ports:
//   clk_i     system clock
//   rst_i     asynchronous active-low reset
//   req_i     per-requester transmit request (hold until ack)
//   data_i    per-requester byte, requester k on [8k+7:8k]
//   ack_o     one-cycle pulse: byte of requester k captured
//   tx_o      serial line, idle high
//   busy_o    frame in progress
//   gnt_id_o  index of last granted requester
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [8*N_REQ-1:0]       data_i,
  output logic [N_REQ-1:0]         ack_o,
  output logic                     tx_o,
  output logic                     busy_o,
  output logic [$clog2(N_REQ)-1:0] gnt_id_o
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] last_gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] cand;
  logic             found;
  logic             start;
  logic [7:0]       req_byte [N_REQ];
  logic [7:0]       sel_byte;

  for (genvar k = 0; k < N_REQ; k++) begin : g_bytes
    assign req_byte[k] = data_i[8*k +: 8];
  end

  // Search upward from last_gnt+1, wrapping; i == N_REQ revisits last_gnt
  // itself so a lone persistent requester is served every frame.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = IDX_W'((32'(last_gnt) + i) % N_REQ);
      if (!found && req_i[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign sel_byte = req_byte[gnt_idx];
  assign start    = found && !busy_o;
  assign gnt_id_o = last_gnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_gnt <= IDX_W'(N_REQ - 1);
      ack_o    <= '0;
    end else begin
      ack_o <= '0;
      if (start) begin
        last_gnt       <= gnt_idx;
        ack_o[gnt_idx] <= 1'b1;
      end
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_serializer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(start),
    .data_i (sel_byte),
    .busy_o (busy_o),
    .tx_o   (tx_o)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (N_REQ=4, CLKS_PER_BIT=16).
// Expected grants/bytes are queued when requests are driven and popped
// when the matching ack appears; the serial frame is then checked cell by
// cell against a bench-side 8N1/8E1 model.
module tb_uart_tx_arbiter;
  import uart_tx_arb_pkg::*;

  localparam int NR   = 4;
  localparam int CPB  = 16;
  localparam int FB   = int'(FRAME_BITS);
  localparam int FCYC = FB * CPB;
  localparam int MAXC = FCYC + 8;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b0;
  logic [NR-1:0]   req_i = '0;
  logic [8*NR-1:0] data_i = '0;
  logic [NR-1:0]   ack_o;
  logic            tx_o;
  logic            busy_o;
  logic [1:0]      gnt_id_o;

  uart_tx_arbiter #(
    .N_REQ       (NR),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .data_i  (data_i),
    .ack_o   (ack_o),
    .tx_o    (tx_o),
    .busy_o  (busy_o),
    .gnt_id_o(gnt_id_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int         id;
    logic [7:0] d;
  } exp_t;
  exp_t exp_q[$];

  logic          tx_tr   [MAXC];
  logic          busy_tr [MAXC];
  logic [NR-1:0] ack_tr  [MAXC];

  function automatic logic exp_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (FB == 11 && k == 9) return ^d;
    return 1'b1;
  endfunction

  // Samples n consecutive negedges, the first being the current one.
  task automatic record(input int n);
    for (int c = 0; c < n; c++) begin
      if (c != 0) @(negedge clk_i);
      tx_tr[c]   = tx_o;
      busy_tr[c] = busy_o;
      ack_tr[c]  = ack_o;
    end
  endtask

  // Locates the first bit cell of the recorded frame that differs from d.
  task automatic scan_frame(input logic [7:0] d, output int bad_cell,
                            output logic [CPB-1:0] got, output logic [CPB-1:0] want);
    logic [CPB-1:0] g, w;
    bad_cell = -1;
    got = '0;
    want = '0;
    for (int k = 0; k < FB; k++) begin
      for (int j = 0; j < CPB; j++) g[j] = tx_tr[k*CPB + j];
      w = {CPB{exp_bit(d, k)}};
      if (bad_cell == -1 && g != w) begin
        bad_cell = k;
        got = g;
        want = w;
      end
    end
  endtask

  task automatic wait_ack(input int budget, output int id, output int waited, output bit ok);
    ok = 1'b0;
    id = -1;
    waited = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (ack_o != '0) begin
        for (int k = NR - 1; k >= 0; k--) if (ack_o[k]) id = k;
        waited = i + 1;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    rst_i = 1'b0;
    req_i = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    for (int ph = 0; ph < 2; ph++) begin
      n_cmp++;
      if (tx_o !== 1'b1) begin n_bad++; $display("FAIL reset_tx ph%0d: got %b want 1", ph, tx_o); end
      n_cmp++;
      if (ack_o !== 4'b0000) begin n_bad++; $display("FAIL reset_ack ph%0d: got %b want 0000", ph, ack_o); end
      n_cmp++;
      if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy ph%0d: got %b want 0", ph, busy_o); end
      n_cmp++;
      if (gnt_id_o !== 2'd3) begin n_bad++; $display("FAIL reset_gnt ph%0d: got %0d want 3", ph, gnt_id_o); end
      if (ph == 0) begin
        rst_i = 1'b1;
        @(negedge clk_i);
      end
    end
  endtask

  task automatic test_single();
    int id, w, bad, nb, na;
    bit ok;
    exp_t e;
    logic [CPB-1:0] g, wt;
    req_i = 4'b0001;
    data_i = '0;
    data_i[7:0] = 8'hA5;
    exp_q.push_back('{0, 8'hA5});
    wait_ack(8, id, w, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL single_ack: no ack in 8 cycles, want ack 0001");
      exp_q.delete();
      req_i = '0;
      return;
    end
    e = exp_q.pop_front();
    req_i = '0;
    n_cmp++;
    if (w !== 1) begin n_bad++; $display("FAIL single_latency: ack after %0d cycles want 1", w); end
    n_cmp++;
    if (ack_o !== (4'b0001 << e.id)) begin n_bad++; $display("FAIL single_ack_vec: got %b want %b", ack_o, 4'b0001 << e.id); end
    n_cmp++;
    if (gnt_id_o !== 2'(e.id)) begin n_bad++; $display("FAIL single_gnt: got %0d want %0d", gnt_id_o, e.id); end
    record(FCYC + 1);
    scan_frame(e.d, bad, g, wt);
    n_cmp++;
    if (bad !== -1) begin n_bad++; $display("FAIL single_frame cell %0d: got %b want %b", bad, g, wt); end
    nb = 0;
    na = 0;
    for (int c = 0; c <= FCYC; c++) begin
      if (busy_tr[c] === 1'b1) nb++;
      if (ack_tr[c] !== 4'b0000) na++;
    end
    n_cmp++;
    if (nb !== FCYC) begin n_bad++; $display("FAIL single_busy_len: got %0d want %0d", nb, FCYC); end
    n_cmp++;
    if (na !== 1) begin n_bad++; $display("FAIL single_ack_pulses: got %0d want 1", na); end
    n_cmp++;
    if (tx_tr[FCYC] !== 1'b1 || busy_tr[FCYC] !== 1'b0)
      begin n_bad++; $display("FAIL single_idle_after: tx=%b busy=%b want tx=1 busy=0", tx_tr[FCYC], busy_tr[FCYC]); end
  endtask

  task automatic test_round_robin();
    int id, w, bad, prev;
    bit ok;
    exp_t e;
    logic [CPB-1:0] g, wt;
    apply_reset();
    data_i = {8'h3C, 8'hC3, 8'h5A, 8'h96};
    req_i = 4'b1111;
    exp_q.push_back('{0, 8'h96});
    exp_q.push_back('{1, 8'h5A});
    exp_q.push_back('{2, 8'hC3});
    exp_q.push_back('{3, 8'h3C});
    exp_q.push_back('{0, 8'h96});
    prev = 0;
    for (int n = 0; n < 5; n++) begin
      wait_ack(FCYC + 20, id, w, ok);
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL rr_ack%0d: no ack within %0d cycles, want requester %0d", n, FCYC + 20, exp_q[0].id);
        break;
      end
      e = exp_q.pop_front();
      n_cmp++;
      if (ack_o !== (4'b0001 << e.id)) begin n_bad++; $display("FAIL rr_order%0d: ack %b want %b", n, ack_o, 4'b0001 << e.id); end
      if (n > 0) begin
        n_cmp++;
        if (cyc - prev !== FCYC + 1) begin n_bad++; $display("FAIL rr_spacing%0d: got %0d want %0d", n, cyc - prev, FCYC + 1); end
      end
      prev = cyc;
      record(FCYC);
      scan_frame(e.d, bad, g, wt);
      n_cmp++;
      if (bad !== -1) begin n_bad++; $display("FAIL rr_frame%0d cell %0d: got %b want %b", n, bad, g, wt); end
    end
    req_i = '0;
    exp_q.delete();
    for (int i = 0; i < FCYC + 5 && busy_o !== 1'b0; i++) @(negedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic test_withdraw();
    int id, w, bad, na, nq;
    bit ok;
    exp_t e;
    logic [CPB-1:0] g, wt;
    data_i[15:8] = 8'h4E;
    data_i[23:16] = 8'hFF;
    req_i = 4'b0010;
    exp_q.push_back('{1, 8'h4E});
    wait_ack(8, id, w, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL wd_ack: no ack in 8 cycles, want ack 0010");
      exp_q.delete();
      req_i = '0;
      return;
    end
    e = exp_q.pop_front();
    req_i = '0;
    n_cmp++;
    if (ack_o !== (4'b0001 << e.id)) begin n_bad++; $display("FAIL wd_ack_vec: got %b want %b", ack_o, 4'b0001 << e.id); end
    fork
      record(FCYC + 1);
      begin
        repeat (30) @(negedge clk_i);
        req_i = 4'b0100;
        data_i[15:8] = 8'h00;
        repeat (40) @(negedge clk_i);
        req_i = '0;
      end
    join
    scan_frame(e.d, bad, g, wt);
    n_cmp++;
    if (bad !== -1) begin n_bad++; $display("FAIL wd_frame cell %0d: got %b want %b", bad, g, wt); end
    na = 0;
    for (int c = 1; c <= FCYC; c++) if (ack_tr[c] !== 4'b0000) na++;
    nq = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk_i);
      if (ack_o !== 4'b0000 || busy_o !== 1'b0 || tx_o !== 1'b1) nq++;
    end
    n_cmp++;
    if (na !== 0) begin n_bad++; $display("FAIL wd_ack_in_frame: got %0d acks want 0", na); end
    n_cmp++;
    if (nq !== 0) begin n_bad++; $display("FAIL wd_extra_frame: got %0d active cycles want 0", nq); end
  endtask

  task automatic test_reset_mid();
    int id, w, bad, nq;
    bit ok;
    exp_t e;
    logic [CPB-1:0] g, wt;
    data_i[23:16] = 8'h00;
    req_i = 4'b0100;
    exp_q.push_back('{2, 8'h00});
    wait_ack(8, id, w, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL rm_ack: no ack in 8 cycles, want ack 0100");
      exp_q.delete();
      req_i = '0;
      return;
    end
    e = exp_q.pop_front();
    req_i = '0;
    n_cmp++;
    if (ack_o !== (4'b0001 << e.id)) begin n_bad++; $display("FAIL rm_ack_vec: got %b want %b", ack_o, 4'b0001 << e.id); end
    repeat (70) @(negedge clk_i);
    n_cmp++;
    if (tx_o !== 1'b0 || busy_o !== 1'b1) begin n_bad++; $display("FAIL rm_pre_bit3: tx=%b busy=%b want tx=0 busy=1", tx_o, busy_o); end
    rst_i = 1'b0;
    #1;
    n_cmp++;
    if (tx_o !== 1'b1) begin n_bad++; $display("FAIL rm_tx_async: got %b want 1", tx_o); end
    n_cmp++;
    if (busy_o !== 1'b0) begin n_bad++; $display("FAIL rm_busy_async: got %b want 0", busy_o); end
    n_cmp++;
    if (gnt_id_o !== 2'd3) begin n_bad++; $display("FAIL rm_gnt_async: got %0d want 3", gnt_id_o); end
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    nq = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (tx_o !== 1'b1 || busy_o !== 1'b0) nq++;
    end
    n_cmp++;
    if (nq !== 0) begin n_bad++; $display("FAIL rm_no_resume: got %0d active cycles want 0", nq); end
    data_i[7:0] = 8'hC6;
    data_i[31:24] = 8'h11;
    req_i = 4'b1001;
    exp_q.push_back('{0, 8'hC6});
    wait_ack(8, id, w, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL rm_post_ack: no ack in 8 cycles, want ack 0001");
      exp_q.delete();
      req_i = '0;
      return;
    end
    e = exp_q.pop_front();
    req_i = '0;
    n_cmp++;
    if (ack_o !== (4'b0001 << e.id)) begin n_bad++; $display("FAIL rm_post_first: got %b want %b", ack_o, 4'b0001 << e.id); end
    record(FCYC + 1);
    scan_frame(e.d, bad, g, wt);
    n_cmp++;
    if (bad !== -1) begin n_bad++; $display("FAIL rm_post_frame cell %0d: got %b want %b", bad, g, wt); end
  endtask

`ifdef UART_TX_ARB_PARITY_EN
  task automatic test_parity();
    int id, w, bad, nb;
    bit ok;
    exp_t e;
    logic [CPB-1:0] g, wt;
    logic [7:0] bytes [2];
    logic       pars  [2];
    bytes[0] = 8'h07; pars[0] = 1'b1;
    bytes[1] = 8'h03; pars[1] = 1'b0;
    for (int n = 0; n < 2; n++) begin
      data_i[7:0] = bytes[n];
      req_i = 4'b0001;
      exp_q.push_back('{0, bytes[n]});
      wait_ack(8, id, w, ok);
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL par_ack%0d: no ack in 8 cycles, want ack 0001", n);
        exp_q.delete();
        req_i = '0;
        return;
      end
      e = exp_q.pop_front();
      req_i = '0;
      record(FCYC + 1);
      scan_frame(e.d, bad, g, wt);
      n_cmp++;
      if (bad !== -1) begin n_bad++; $display("FAIL par_frame%0d cell %0d: got %b want %b", n, bad, g, wt); end
      n_cmp++;
      if (tx_tr[9*CPB + CPB/2] !== pars[n])
        begin n_bad++; $display("FAIL par_cell%0d: got %b want %b", n, tx_tr[9*CPB + CPB/2], pars[n]); end
      nb = 0;
      for (int c = 0; c <= FCYC; c++) if (busy_tr[c] === 1'b1) nb++;
      n_cmp++;
      if (nb !== 176) begin n_bad++; $display("FAIL par_len%0d: got %0d want 176", n, nb); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_withdraw();
    test_reset_mid();
`ifdef UART_TX_ARB_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded 500000 time units");
    $fatal(1);
  end

endmodule
